// File: rtl/fregfile_sb.sv
// Floating-point register file with an init sweep, write-first read bypass and
// per-register pending scoreboard. Optional WAW check output: FREGFILE_WAW_CHK_EN.
//
// state   | meaning
// ST_INIT | sweeping zeros into the array, one entry per cycle; inputs ignored
// ST_RUN  | normal operation, ready high
module fregfile_sb #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush
`ifdef FREGFILE_WAW_CHK_EN
  ,
  output logic                  waw_err
`endif
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic              state;
  logic [ADDR_W-1:0] idx;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [XLEN-1:0]   mem [NREG];
  logic              run;

  assign run   = (state == ST_RUN);
  assign ready = run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_INIT;
      idx     <= '0;
      pending <= '0;
    end else if (!run) begin
      idx <= idx + ADDR_W'(1);
      if (idx == ADDR_W'(NREG - 1)) state <= ST_RUN;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Array has no reset of its own; the sweep zeroes it. Port A is written last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        mem[idx] <= '0;
      end else begin
        if (wb_en) mem[wb_addr] <= wb_data;
        if (wa_en) mem[wa_addr] <= wa_data;
      end
    end
  end

  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NREG; i++) begin
      if (iss_en && iss_addr == ADDR_W'(i))     pending_nxt[i] = 1'b1;
      else if (flush)                           pending_nxt[i] = 1'b0;
      else if (wb_en && wb_addr == ADDR_W'(i))  pending_nxt[i] = 1'b0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              wa_hit;
    logic              wb_hit;
    assign a      = rd_addr[k*ADDR_W +: ADDR_W];
    assign wa_hit = wa_en && (wa_addr == a);
    assign wb_hit = wb_en && (wb_addr == a);
    assign rd_data[k*XLEN +: XLEN] = !run  ? '0 :
                                     wa_hit ? wa_data :
                                     wb_hit ? wb_data : mem[a];
    // A writeback landing this cycle already supplies the operand.
    assign rd_busy[k] = run && pending[a] && !wb_hit;
  end

`ifdef FREGFILE_WAW_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst || !run) waw_err <= 1'b0;
    else waw_err <= iss_en && pending[iss_addr] && !(wb_en && wb_addr == iss_addr);
  end
`endif

endmodule

// File: tb/tb_fregfile_sb.sv
// Randomized scoreboard bench for fregfile_sb: the driver pushes expected outputs
// from an array-based reference model, a negedge monitor pops and compares.
module tb_fregfile_sb;
  localparam int XLEN = 32, ADDR_W = 5, NRD = 3, NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  ready;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wa_en, wb_en, iss_en, flush;
  logic [ADDR_W-1:0]     wa_addr, wb_addr, iss_addr;
  logic [XLEN-1:0]       wa_data, wb_data;
  logic                  waw_err;

  fregfile_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
`ifdef FREGFILE_WAW_CHK_EN
    , .waw_err(waw_err)
`endif
  );
`ifndef FREGFILE_WAW_CHK_EN
  assign waw_err = 1'b0;
`endif

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic                rdy;
    logic                waw;
    int                  id;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: architectural state as plain arrays.
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_pend [NREG];
  bit              m_ready = 0;
  int              m_cnt = 0;
  bit              m_waw = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp, input int id);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready", 32'(ready), 32'(e.rdy), e.id);
      for (int k = 0; k < NRD; k++)
        check($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], e.data[k*XLEN +: XLEN], e.id);
      check("rd_busy", 32'(rd_busy), 32'(e.busy), e.id);
`ifdef FREGFILE_WAW_CHK_EN
      check("waw_err", 32'(waw_err), 32'(e.waw), e.id);
`endif
    end
  end

  task automatic model_edge();
    if (!rst) begin
      m_ready = 0; m_cnt = 0; m_waw = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NREG) m_ready = 1;
      m_waw = 0;
    end else begin
      m_waw = iss_en && m_pend[iss_addr] && !(wb_en && wb_addr == iss_addr);
      if (wb_en) m_mem[wb_addr] = wb_data;
      if (wa_en) m_mem[wa_addr] = wa_data;
      if (flush) foreach (m_pend[i]) m_pend[i] = 0;
      else if (wb_en) m_pend[wb_addr] = 0;
      if (iss_en) m_pend[iss_addr] = 1;
    end
  endtask

  task automatic step();
    exp_t e;
    logic [ADDR_W-1:0] a;
    e.data = '0;
    e.busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (m_ready) begin
        if (wa_en && wa_addr == a)      e.data[k*XLEN +: XLEN] = wa_data;
        else if (wb_en && wb_addr == a) e.data[k*XLEN +: XLEN] = wb_data;
        else                            e.data[k*XLEN +: XLEN] = m_mem[a];
        e.busy[k] = m_pend[a] && !(wb_en && wb_addr == a);
      end
    end
    e.rdy = m_ready;
    e.waw = m_waw;
    e.id  = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; wa_en = 0; wb_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic randomize_inputs(input bit narrow);
    int hi;
    hi = narrow ? 7 : NREG - 1;
    wa_en = ($urandom_range(0, 2) == 0);
    wb_en = ($urandom_range(0, 2) == 0);
    iss_en = ($urandom_range(0, 2) == 0);
    flush = ($urandom_range(0, 15) == 0);
    wa_addr = ADDR_W'($urandom_range(0, hi));
    wb_addr = ADDR_W'($urandom_range(0, hi));
    iss_addr = ADDR_W'($urandom_range(0, hi));
    wa_data = $urandom;
    wb_data = $urandom;
    set_rd($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    wa_addr = '0; wb_addr = '0; iss_addr = '0; wa_data = '0; wb_data = '0;
    set_rd(0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    repeat (2) step();

    // Init sweep; enables toggling during INIT must be dropped.
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      randomize_inputs(0);
      rst = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < NREG; i += 3) begin set_rd(i, i + 1, (i + 2) % NREG); step(); end

    // Bypass and port A priority on same-index collision.
    wa_en = 1; wa_addr = 5; wa_data = 32'h3F80_0000;
    wb_en = 1; wb_addr = 5; wb_data = 32'h4000_0000;
    set_rd(5, 5, 0); step();
    idle(); set_rd(5, 6, 5); step();

    // Scoreboard set / writeback unblock.
    iss_en = 1; iss_addr = 7; step();
    idle(); set_rd(7, 0, 7); step();
    wb_en = 1; wb_addr = 7; wb_data = 32'h4049_0FDB; step();
    idle(); step();

    // Issue+writeback same index, then flush with issue.
    iss_en = 1; iss_addr = 3; wb_en = 1; wb_addr = 3; wb_data = 32'h1234_5678; step();
    idle(); set_rd(3, 3, 3); step();
    iss_en = 1; iss_addr = 2; step();
    iss_addr = 4; step();
    flush = 1; iss_addr = 9; step();
    idle(); set_rd(2, 4, 9); step();
    set_rd(3, 9, 2); step();

    // Reset mid-operation.
    iss_en = 1; iss_addr = 1; step();
    iss_addr = 7; step();
    idle(); wa_en = 1; wa_addr = 1; wa_data = 32'h1; step();
    idle(); rst = 0; set_rd(1, 7, 0); step();
    rst = 1; wa_en = 1; wa_addr = 1; wa_data = 32'hFFFF_FFFF;
    iss_en = 1; iss_addr = 1;
    repeat (NREG) step();
    idle(); set_rd(1, 7, 2); step();

    // WAW detection: back-to-back issue, then issue covered by writeback.
    iss_en = 1; iss_addr = 4; step();
    step();
    idle(); step();
    step();
    iss_en = 1; iss_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'hCAFE_0004; step();
    idle(); set_rd(4, 4, 4); step();
    step();

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 2500; i++) begin
      randomize_inputs($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 599) != 0);
      step();
    end

    idle(); step();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fregfile_sb.md
Name: fregfile_sb

Overview:
Parametrised floating-point register file with scoreboard, the next-generation FP register file of the 5-stage pipeline.
- Provides NRD combinational read ports, for example rs1/rs2/rs3 for fused multiply-add.
- Has two write ports: port A for single-cycle FP ops, port B for long-latency FDIV/FSQRT/FLW results.
- Read data bypasses same-cycle writes.
- Tracks registers with an outstanding long-latency write in per-register pending bits.
- After reset, clears its storage by a sequential sweep.

Parameters:
XLEN, 32, data width of each register.
ADDR_W, 5, register index width; NREG = 2**ADDR_W entries.
NRD, 3, number of read ports.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  reset, synchronous, active-low.
ready  out  1  high once the init sweep has finished.
rd_addr  in  NRD*ADDR_W  packed read indices; port k at [k*ADDR_W +: ADDR_W].
rd_data  out  NRD*XLEN  packed read data; port k at [k*XLEN +: XLEN].
rd_busy  out  NRD  port k operand has a pending long-latency write.
wa_en  in  1  port A write enable.
wa_addr  in  ADDR_W  port A index.
wa_data  in  XLEN  port A data.
wb_en  in  1  port B write enable; also clears the pending bit.
wb_addr  in  ADDR_W  port B index.
wb_data  in  XLEN  port B data.
iss_en  in  1  long-latency op issued; marks its destination pending.
iss_addr  in  ADDR_W  destination of the issued op.
flush  in  1  clear all pending bits (pipeline flush).

Behaviour:
- Reset, when rst==0 at posedge:
  - state<=INIT, sweep idx<=0, all pending<=0, ready<=0.
  - Applies at any time, including mid-RUN or mid-INIT.
- INIT:
  - Each cycle with rst==1, writes 0 to entry idx, then idx<=idx+1.
  - After the cycle that writes idx==NREG-1, state<=RUN and ready<=1.
  - ready is therefore first high NREG posedges after rst is released.
  - wa_en, wb_en, iss_en and flush are ignored during INIT.
  - rd_data reads 0 and rd_busy reads 0 during INIT.
- RUN writes:
  - Writes land at posedge.
  - Entry 0 is an ordinary register (not hardwired zero).
  - If wa_en and wb_en target the same index, port A data is stored (port A is the younger instruction).
- Read port k, combinational:
  - If wa_en && wa_addr==rd_addr_k, return wa_data.
  - Else if wb_en && wb_addr==rd_addr_k, return wb_data.
  - Else return the array entry.
  - Write-first: zero-cycle bypass.
- Scoreboard (RUN only), next value of pending[i] in priority order:
  1. Set if iss_en && iss_addr==i.
  2. Else clear if flush.
  3. Else clear if wb_en && wb_addr==i.
  4. Else hold.
- Scoreboard boundary cases:
  - Issue and writeback to the same index in the same cycle: the index ends pending.
  - Flush with issue in the same cycle: only iss_addr ends pending.
  - Port A does not affect pending bits.
- rd_busy[k] = pending[rd_addr_k] && !(wb_en && wb_addr==rd_addr_k). The result arriving this cycle unblocks the reader.
- Issue to an already-pending index is accepted; the index stays pending (WAW is avoided by upstream stall).
- No output is registered except ready and the optional waw_err.

Optional Feature:
Macro FREGFILE_WAW_CHK_EN.
- Defined:
  - Adds output waw_err (1 bit, reset 0).
  - waw_err is a one-cycle registered pulse the cycle after iss_en in RUN targets an index whose pending bit is set and is not cleared by wb_en in that same cycle.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset sweep: hold rst=0 for 3 cycles, release → ready=0 for 32 posedges then 1; every rd_addr reads 0x00000000.
2. Write/bypass: RUN, wa_en wa_addr=5 wa_data=0x3F800000, rd_addr port0=5 in the same cycle → rd_data0=0x3F800000 combinationally; next cycle the array returns it. Simultaneously wb_en wb_addr=5 wb_data=0x40000000 → 0x3F800000 is stored.
3. Scoreboard: iss_en iss_addr=7; next cycle rd_addr=7 → rd_busy=1. wb_en wb_addr=7 wb_data=0x40490FDB → rd_busy=0 and rd_data=0x40490FDB in that same cycle; pending clear afterwards.
4. Collisions:
   - iss_en addr=3 and wb_en addr=3 in the same cycle → pending[3]=1.
   - flush with iss_en addr=9, pending{2,4} previously set → only pending[9]=1.
5. Reset mid-operation: pending{1,7}, reg 1=0x1, assert rst=0 for one cycle → ready=0, pending all 0, after 32 cycles reg 1 reads 0; writes issued during INIT are dropped.
6. (FREGFILE_WAW_CHK_EN) issue addr=4 twice on consecutive cycles → waw_err=1 for exactly one cycle after the second issue. Repeat with wb_en addr=4 alongside the second issue → waw_err stays 0.
